// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the memory-access stage.
//   - DATA_WIDTH / REG_ADDR_WIDTH / BE_WIDTH : datapath geometry
//   - mem_size_e  : load/store size encodings, equal to funct3
//   - mem_state_e : memory-stage FSM states
//   - wb_sel_e    : write-back source select carried down the pipe
//   - ex2mem_t    : EX/MEM bundle consumed by mem_stage
//   - mem2wb_t    : MEM/WB bundle produced by mem_stage (fields under .data)
package mem_stage_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int BE_WIDTH       = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        MEM_BYTE  = 3'b000,
        MEM_HALF  = 3'b001,
        MEM_WORD  = 3'b010,
        MEM_BYTEU = 3'b100,
        MEM_HALFU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     alu_result;
        logic [DATA_WIDTH-1:0]     rs2_data;
        logic [2:0]                funct3;
        logic                      MemRead;
        logic                      MemWrite;
        wb_sel_e                   WBSel;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic [DATA_WIDTH-1:0]     instruction;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      RegWrite;
    } ex2mem_t;

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     alu_result;
        logic [DATA_WIDTH-1:0]     rd_data;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic [DATA_WIDTH-1:0]     instruction;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      RegWrite;
        wb_sel_e                   WBSel;
    } mem2wb_data_t;

    typedef struct packed {
        mem2wb_data_t data;
    } mem2wb_t;

    // Unsupported funct3 encodings are folded into the misaligned case so
    // they never reach the memory port.
    function automatic logic access_misaligned(input logic [2:0] funct3,
                                               input logic [1:0] offset);
        logic bad;
        case (funct3)
            MEM_BYTE, MEM_BYTEU: bad = 1'b0;
            MEM_HALF, MEM_HALFU: bad = offset[0];
            MEM_WORD:            bad = (offset != 2'b00);
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational load/store lane handling.
//   funct3     in  : access size / signedness
//   offset     in  : byte offset within the word (addr[1:0])
//   store_data in  : rs2 value to be stored
//   load_word  in  : full memory word returned for a load
//   be         out : byte enables for a store
//   wdata      out : store data replicated across byte lanes
//   load_data  out : extracted and sign/zero-extended load value
//   misalign   out : access misaligned or funct3 unsupported
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] load_word,
    output logic [BE_WIDTH-1:0]   be,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misalign
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Replicating the data across lanes lets the byte enables alone pick
    // the destination lane; no data shifter is needed.
    always_comb begin
        be    = '0;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = BE_WIDTH'(4'b0001 << offset);
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = BE_WIDTH'(4'b0011 << offset);
                wdata = {2{store_data[15:0]}};
            end
            2'b10: begin
                be    = '1;
                wdata = store_data;
            end
            default: begin
                be    = '0;
                wdata = store_data;
            end
        endcase
    end

    // Halfword accesses only reach memory when offset[0] = 0, so offset[1]
    // alone selects the half.
    assign load_byte = load_word[{offset, 3'b000} +: 8];
    assign load_half = load_word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        load_data = '0;
        case (funct3)
            MEM_BYTE:  load_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
            MEM_BYTEU: load_data = {{(DATA_WIDTH-8){1'b0}}, load_byte};
            MEM_HALF:  load_data = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
            MEM_HALFU: load_data = {{(DATA_WIDTH-16){1'b0}}, load_half};
            MEM_WORD:  load_data = load_word;
            default:   load_data = '0;
        endcase
    end

    assign misalign = access_misaligned(funct3, offset);

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage core.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus_in          : EX/MEM bundle (held stable by upstream while stall_o)
//   bus_out         : registered MEM/WB bundle (bus_out.data.*)
//   dmem_req_o/we_o : data-memory request / store flag
//   dmem_addr_o     : word-aligned address
//   dmem_wdata_o/be_o : lane-aligned store data / byte enables
//   dmem_gnt_i      : request accepted
//   dmem_rvalid_i   : load data valid (only honoured in WAIT_RSP)
//   dmem_rdata_i    : full memory word
//   stall_o         : hold upstream stages
//   misalign_o      : one-cycle pulse alongside a faulting instruction
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  ex2mem_t               bus_in,
    output mem2wb_t               bus_out,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [BE_WIDTH-1:0]   dmem_be_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  stall_o,
    output logic                  misalign_o
);

    mem_state_e            state;
    logic                  is_mem;
    logic                  is_store;
    logic                  misalign;
    logic                  fault;
    logic                  mem_op;
    logic                  store_done;
    logic                  load_done;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] load_data;

    lsu_align u_align (
        .funct3     (bus_in.funct3),
        .offset     (bus_in.alu_result[1:0]),
        .store_data (bus_in.rs2_data),
        .load_word  (dmem_rdata_i),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    assign is_mem   = bus_in.MemRead | bus_in.MemWrite;
    assign is_store = bus_in.MemWrite;
    assign fault    = bus_in.valid & is_mem & misalign;
    assign mem_op   = bus_in.valid & is_mem & ~misalign;

    // Request is raised in the same cycle the access arrives, then held in
    // REQ; upstream keeps bus_in stable so the payload stays put. Reset
    // forces the combinational outputs low as well as the state.
    assign dmem_req_o   = rst_n & (((state == IDLE) & mem_op) | (state == REQ));
    assign dmem_we_o    = dmem_req_o & is_store;
    assign dmem_addr_o  = dmem_req_o ? {bus_in.alu_result[DATA_WIDTH-1:2], 2'b00} : '0;
    assign dmem_wdata_o = (dmem_req_o & is_store) ? wdata : '0;
    assign dmem_be_o    = (dmem_req_o & is_store) ? be : '0;

    // gnt in WAIT_RSP is ignored because req is low there; rvalid outside
    // WAIT_RSP never completes anything.
    assign store_done = dmem_req_o & dmem_gnt_i & is_store;
    assign load_done  = (state == WAIT_RSP) & dmem_rvalid_i;
    assign stall_o    = rst_n & mem_op & ~(store_done | load_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bus_out    <= '0;
            misalign_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        if (dmem_gnt_i) state <= is_store ? IDLE : WAIT_RSP;
                        else            state <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) state <= is_store ? IDLE : WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (dmem_rvalid_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            misalign_o <= fault;

            if (stall_o || !bus_in.valid) begin
                bus_out <= '0;
            end else begin
                bus_out.data.valid       <= 1'b1;
                bus_out.data.alu_result  <= bus_in.alu_result;
                bus_out.data.rd_data     <= load_done ? load_data : '0;
                bus_out.data.pc_plus4    <= bus_in.pc_plus4;
                bus_out.data.instruction <= bus_in.instruction;
                bus_out.data.rd_addr     <= bus_in.rd_addr;
                bus_out.data.RegWrite    <= bus_in.RegWrite & ~fault;
                bus_out.data.WBSel       <= bus_in.WBSel;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    ex2mem_t     bus_in;
    mem2wb_t     bus_out;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o, misalign_o;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_in        (bus_in),
        .bus_out       (bus_out),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .stall_o       (stall_o),
        .misalign_o    (misalign_o)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (mem.exists(k)) return mem[k];
        return k ^ 32'hA5A5_0F0F;
    endfunction

    // Runs one instruction through the stage until it lands in MEM/WB.
    // Expected values come from the ISA-level rules: sizes in bytes,
    // masks, byte replication by multiplication, and a word memory.
    task automatic run_op(input string name, input logic v, input logic [2:0] f3,
                          input logic mr, input logic mw, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [4:0] rd, input logic rw,
                          input int gd, input int rdl,
                          output int req_cycles, output int stalls,
                          output logic [3:0] seen_be, output logic [31:0] seen_wdata,
                          output logic [31:0] seen_addr);
        ex2mem_t     b;
        mem2wb_t     exp;
        logic        misal, is_mem, memop, exp_req, exp_stall;
        int          off, n, phase, gcnt, rcnt;
        bit          done;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, word, ld, mask;

        b.valid = v; b.alu_result = addr; b.rs2_data = rs2; b.funct3 = f3;
        b.MemRead = mr; b.MemWrite = mw; b.WBSel = wb_sel_e'($urandom_range(0, 2));
        b.pc_plus4 = $urandom; b.instruction = $urandom; b.rd_addr = rd; b.RegWrite = rw;

        off = int'(addr[1:0]);
        n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        case (f3)
            3'b000, 3'b100: misal = 1'b0;
            3'b001, 3'b101: misal = (off % 2) != 0;
            3'b010:         misal = off != 0;
            default:        misal = 1'b1;
        endcase
        is_mem = mr | mw;
        memop  = v & is_mem & ~misal;
        exp_be = 4'(((1 << n) - 1) << off);
        exp_wd = (n == 1) ? rs2[7:0] * 32'h0101_0101 :
                 (n == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
        word = mem_rd(addr);
        mask = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
        ld   = (word >> (8 * off)) & mask;
        if (!f3[2] && n < 4 && ld[8 * n - 1]) ld = ld | ~mask;

        exp = '0;
        if (v) begin
            exp.data.valid       = 1'b1;
            exp.data.alu_result  = addr;
            exp.data.pc_plus4    = b.pc_plus4;
            exp.data.instruction = b.instruction;
            exp.data.rd_addr     = rd;
            exp.data.WBSel       = b.WBSel;
            exp.data.RegWrite    = rw & ~(is_mem & misal);
            exp.data.rd_data     = (memop && !mw) ? ld : 32'h0;
        end

        req_cycles = 0; stalls = 0; phase = 0; gcnt = 0; rcnt = 0; done = 0;
        seen_be = '0; seen_wdata = '0; seen_addr = '0;
        @(negedge clk);
        bus_in = b;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            dmem_gnt_i = memop && phase == 0 && gcnt == gd;
            if (phase == 1) begin
                dmem_rvalid_i = (rcnt == rdl);
                dmem_rdata_i  = dmem_rvalid_i ? word : $urandom;
            end else begin
                // stray responses before the grant must be ignored
                dmem_rvalid_i = memop && ($urandom_range(0, 3) == 0);
                dmem_rdata_i  = $urandom;
            end
            #1;
            exp_req   = memop && phase == 0;
            exp_stall = memop && !((mw && dmem_gnt_i) || (phase == 1 && dmem_rvalid_i));
            vectors++;
            if (dmem_req_o !== exp_req) begin
                miscompares++;
                $display("FAIL %s req cyc%0d: got %0b want %0b", name, c, dmem_req_o, exp_req);
            end
            vectors++;
            if (stall_o !== exp_stall) begin
                miscompares++;
                $display("FAIL %s stall cyc%0d: got %0b want %0b", name, c, stall_o, exp_stall);
            end
            if (exp_req) begin
                req_cycles++;
                seen_be = dmem_be_o; seen_wdata = dmem_wdata_o; seen_addr = dmem_addr_o;
                vectors++;
                if (dmem_we_o !== mw || dmem_addr_o !== {addr[31:2], 2'b00} ||
                    (mw && (dmem_be_o !== exp_be || dmem_wdata_o !== exp_wd))) begin
                    miscompares++;
                    $display("FAIL %s payload cyc%0d: got we=%0b a=%h be=%b wd=%h want we=%0b a=%h be=%b wd=%h",
                             name, c, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                             mw, {addr[31:2], 2'b00}, exp_be, exp_wd);
                end
            end
            @(posedge clk); #1;
            if (exp_stall) begin
                stalls++;
                vectors++;
                if (bus_out.data.valid !== 1'b0 || bus_out.data.RegWrite !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s bubble cyc%0d: got v=%0b rw=%0b want 0 0", name, c,
                             bus_out.data.valid, bus_out.data.RegWrite);
                end
                if (phase == 0) begin
                    if (dmem_gnt_i) phase = 1;
                    else gcnt++;
                end else begin
                    rcnt++;
                end
            end else begin
                done = 1;
                vectors++;
                if (bus_out !== exp) begin
                    miscompares++;
                    $display("FAIL %s entry: got %h want %h", name, bus_out, exp);
                end
                vectors++;
                if (misalign_o !== (v & is_mem & misal)) begin
                    miscompares++;
                    $display("FAIL %s misalign: got %0b want %0b", name, misalign_o, v & is_mem & misal);
                end
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s timeout: got no completion want completion", name);
        end
        if (memop && mw) begin
            for (int i = 0; i < 4; i++)
                if (exp_be[i]) word[8 * i +: 8] = exp_wd[8 * i +: 8];
            mem[{addr[31:2], 2'b00}] = word;
        end
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_in = '0;
        bus_in.valid = 1'b1; bus_in.MemRead = 1'b1; bus_in.funct3 = 3'b010;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        #2;
        vectors++;
        if (bus_out !== '0 || misalign_o !== 1'b0 || dmem_req_o !== 1'b0 ||
            dmem_we_o !== 1'b0 || stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got out=%h mis=%0b req=%0b we=%0b stall=%0b want all 0",
                     bus_out, misalign_o, dmem_req_o, dmem_we_o, stall_o);
        end
        @(negedge clk);
        bus_in = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        int rq, st; logic [3:0] be; logic [31:0] wd, ad;
        run_op("alu", 1, 3'b000, 0, 0, 32'h0000_1234, $urandom, 5'd5, 1, 0, 0, rq, st, be, wd, ad);
        vectors++;
        if (bus_out.data.valid !== 1'b1 || bus_out.data.alu_result !== 32'h1234 ||
            bus_out.data.rd_addr !== 5'd5 || rq != 0 || st != 0) begin
            miscompares++;
            $display("FAIL alu direct: got v=%0b alu=%h rd=%0d req=%0d st=%0d want 1 1234 5 0 0",
                     bus_out.data.valid, bus_out.data.alu_result, bus_out.data.rd_addr, rq, st);
        end
    endtask

    task automatic test_store_byte_delayed();
        int rq, st; logic [3:0] be; logic [31:0] wd, ad;
        run_op("sb_dly", 1, 3'b000, 0, 1, 32'h0000_1003, 32'hAABB_CCDD, 5'd0, 0, 2, 0, rq, st, be, wd, ad);
        vectors++;
        if (rq != 3 || st != 2 || be !== 4'b1000 || wd !== 32'hDDDD_DDDD || ad !== 32'h1000) begin
            miscompares++;
            $display("FAIL sb_dly direct: got req=%0d st=%0d be=%b wd=%h a=%h want 3 2 1000 dddddddd 1000",
                     rq, st, be, wd, ad);
        end
    endtask

    task automatic test_load_byte();
        int rq, st; logic [3:0] be; logic [31:0] wd, ad;
        mem[32'h2000] = 32'h0000_8000;
        run_op("lb", 1, 3'b000, 1, 0, 32'h0000_2001, 0, 5'd7, 1, 0, 0, rq, st, be, wd, ad);
        vectors++;
        if (bus_out.data.rd_data !== 32'hFFFF_FF80 || bus_out.data.RegWrite !== 1'b1 || st != 1) begin
            miscompares++;
            $display("FAIL lb direct: got rd=%h rw=%0b st=%0d want ffffff80 1 1",
                     bus_out.data.rd_data, bus_out.data.RegWrite, st);
        end
        run_op("lbu", 1, 3'b100, 1, 0, 32'h0000_2001, 0, 5'd7, 1, 0, 0, rq, st, be, wd, ad);
        vectors++;
        if (bus_out.data.rd_data !== 32'h0000_0080) begin
            miscompares++;
            $display("FAIL lbu direct: got %h want 00000080", bus_out.data.rd_data);
        end
    endtask

    task automatic test_load_half_misalign();
        int rq, st; logic [3:0] be; logic [31:0] wd, ad;
        mem[32'h2000] = 32'h7FFF_0000;
        run_op("lh", 1, 3'b001, 1, 0, 32'h0000_2002, 0, 5'd8, 1, 1, 2, rq, st, be, wd, ad);
        vectors++;
        if (bus_out.data.rd_data !== 32'h0000_7FFF) begin
            miscompares++;
            $display("FAIL lh direct: got %h want 00007fff", bus_out.data.rd_data);
        end
        run_op("lw_mis", 1, 3'b010, 1, 0, 32'h0000_2002, 0, 5'd8, 1, 0, 0, rq, st, be, wd, ad);
        vectors++;
        if (rq != 0 || misalign_o !== 1'b1 || bus_out.data.RegWrite !== 1'b0 || bus_out.data.valid !== 1'b1) begin
            miscompares++;
            $display("FAIL lw_mis direct: got req=%0d mis=%0b rw=%0b v=%0b want 0 1 0 1",
                     rq, misalign_o, bus_out.data.RegWrite, bus_out.data.valid);
        end
    endtask

    task automatic test_reset_mid_load();
        int rq, st; logic [3:0] be; logic [31:0] wd, ad;
        @(negedge clk);
        bus_in = '0;
        bus_in.valid = 1'b1; bus_in.MemRead = 1'b1; bus_in.funct3 = 3'b010;
        bus_in.alu_result = 32'h2004; bus_in.RegWrite = 1'b1; bus_in.rd_addr = 5'd9;
        dmem_gnt_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus_out !== '0 || dmem_req_o !== 1'b0 || stall_o !== 1'b0 || misalign_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: got out=%h req=%0b stall=%0b mis=%0b want all 0",
                     bus_out, dmem_req_o, stall_o, misalign_o);
        end
        @(negedge clk);
        bus_in = '0;
        rst_n = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus_out.data.valid !== 1'b0 || dmem_req_o !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_stale%0d: got v=%0b req=%0b want 0 0", i, bus_out.data.valid, dmem_req_o);
            end
        end
        dmem_rvalid_i = 1'b0;
        run_op("alu_after_rst", 1, 3'b000, 0, 0, $urandom, $urandom, 5'd3, 1, 0, 0, rq, st, be, wd, ad);
    endtask

    task automatic test_back_to_back();
        int rq, st; logic [3:0] be; logic [31:0] wd, ad; logic [31:0] val;
        val = $urandom;
        run_op("b2b_sw", 1, 3'b010, 0, 1, 32'h0000_2010, val, 5'd0, 0, 0, 0, rq, st, be, wd, ad);
        vectors++;
        if (st != 0) begin
            miscompares++;
            $display("FAIL b2b_sw stalls: got %0d want 0", st);
        end
        run_op("b2b_lw", 1, 3'b010, 1, 0, 32'h0000_2010, 0, 5'd4, 1, 0, 0, rq, st, be, wd, ad);
        vectors++;
        if (st != 1 || bus_out.data.rd_data !== val) begin
            miscompares++;
            $display("FAIL b2b_lw: got st=%0d rd=%h want 1 %h", st, bus_out.data.rd_data, val);
        end
    endtask

    task automatic test_random();
        int rq, st; logic [3:0] be; logic [31:0] wd, ad;
        logic [2:0] lf3 [12];
        logic [2:0] sf3 [7];
        int kind;
        logic [31:0] addr;
        lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        sf3 = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd7};
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            addr = 32'h3000 + $urandom_range(0, 15);
            if (kind < 2)
                run_op("rnd_alu", 1, 3'($urandom), 0, 0, $urandom, $urandom, 5'($urandom), 1'($urandom),
                       0, 0, rq, st, be, wd, ad);
            else if (kind < 6)
                run_op("rnd_ld", 1, lf3[$urandom_range(0, 11)], 1, 0, addr, 0, 5'($urandom), 1,
                       $urandom_range(0, 3), $urandom_range(0, 3), rq, st, be, wd, ad);
            else if (kind < 9)
                run_op("rnd_st", 1, sf3[$urandom_range(0, 6)], 0, 1, addr, $urandom, 5'd0, 0,
                       $urandom_range(0, 3), 0, rq, st, be, wd, ad);
            else
                run_op("rnd_bub", 0, 3'($urandom), 1'($urandom), 0, addr, $urandom, 5'($urandom), 1,
                       0, 0, rq, st, be, wd, ad);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_byte_delayed();
        test_load_byte();
        test_load_half_misalign();
        test_reset_mid_load();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V core and the producer (MASTER) side of MEM2WB_if.
- Consumes the EX/MEM bundle and runs at most one load/store on the data-memory req/gnt/rvalid port.
- Aligns store data into byte lanes and sign/zero-extends load data.
- Owns the MEM/WB pipeline register; stalls upstream while a memory transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width (from core_pkg).
- REG_ADDR_WIDTH, 5, register index width (from core_pkg).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- bus_in  EX2MEM_if.SLAVE  bundle  valid, alu_result, rs2_data, funct3[2:0], MemRead, MemWrite, WBSel, pc_plus4, instruction, rd_addr, RegWrite
- bus_out  MEM2WB_if.MASTER  bundle  registered data.{valid, alu_result, rd_data, pc_plus4, instruction, rd_addr, RegWrite, WBSel}
- dmem_req_o  out  1  request valid
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  DATA_WIDTH  word address, alu_result with [1:0] = 0
- dmem_wdata_o  out  DATA_WIDTH  lane-aligned store data
- dmem_be_o  out  4  byte enables
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  load data valid; earliest one cycle after gnt
- dmem_rdata_i  in  DATA_WIDTH  full memory word
- stall_o  out  1  hold EX/MEM and earlier stages
- misalign_o  out  1  registered one-cycle pulse alongside the faulting instruction

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State = IDLE.
  - All bus_out.data fields = 0.
  - misalign_o = 0.
  - dmem_req_o, dmem_we_o and stall_o = 0.
- FSM states: IDLE, REQ, WAIT_RSP.
- mem_op = bus_in.valid & (MemRead | MemWrite) & aligned.
- Non-memory instruction (valid and neither MemRead nor MemWrite):
  - Latched into MEM/WB on the next edge (1-cycle latency).
  - rd_data = 0.
- IDLE with mem_op:
  - Drive dmem_req_o = 1 combinationally in the same cycle.
  - gnt in that cycle: a store completes (latched into MEM/WB on that edge, stays IDLE); a load goes to WAIT_RSP.
  - No gnt: go to REQ.
- REQ:
  - Hold req, we, addr, wdata and be stable until gnt.
  - On gnt: a store completes; a load goes to WAIT_RSP.
- WAIT_RSP:
  - req = 0.
  - On rvalid: latch extended load data into rd_data, write MEM/WB, return to IDLE.
- stall_o = mem_op & ~completing-this-cycle.
  - Completing means a store gnt, or rvalid in WAIT_RSP.
  - Combinational; upstream holds bus_in stable while stall_o = 1.
- Bubbles: on every stalled edge, MEM/WB loads valid = 0 and RegWrite = 0. Other fields are don't-care but driven to 0.
- Store lanes, with off = addr[1:0]:
  - SB (funct3 000): be = 0001 << off, wdata = {4{rs2[7:0]}}.
  - SH (001): be = 0011 << off, wdata = {2{rs2[15:0]}}.
  - SW (010): be = 1111, wdata = rs2.
- Load extraction:
  - LB/LBU (000/100): byte at off, sign/zero-extended.
  - LH/LHU (001/101): halfword at off, sign/zero-extended.
  - LW (010): full word.
- Misaligned access (halfword with addr[0] = 1, or word with addr[1:0] != 0):
  - No dmem request, no stall.
  - MEM/WB latches valid = 1 and RegWrite = 0 next edge.
  - misalign_o = 1 for that one cycle.
- Unsupported funct3 (011, 110, 111) with MemRead/MemWrite: treated as misaligned.
- dmem_rvalid_i outside WAIT_RSP is ignored, including a stale response after reset.
- gnt and rvalid asserted together in WAIT_RSP: only rvalid is honoured, because req = 0 there.
- Reset mid-transaction: the transaction is abandoned and the FSM returns to IDLE immediately.
- bus_in.valid = 0: MEM/WB loads a bubble; no request.

Decomposition:
- Additions to core_pkg:
  - mem_size_e (BYTE, HALF, WORD, BYTEU, HALFU mapped to funct3).
  - mem_state_e (IDLE, REQ, WAIT_RSP).
  - The existing WBSel enum, reused.
- One combinational sub-module, lsu_align: store lane/be generation, load extraction/extension, misalign detect.
- mem_stage holds the FSM, the stall logic and the MEM/WB register.

Test Plan:
- ALU op, alu_result = 0x0000_1234, rd_addr = 5, RegWrite = 1 -> next cycle bus_out valid = 1, alu_result = 0x1234, rd_addr = 5; no dmem_req_o; stall_o = 0 throughout.
- SB at 0x1003 with rs2 = 0xAABBCCDD, gnt delayed 2 cycles -> req held 3 cycles with be = 1000, wdata = 0xDDDDDDDD, addr = 0x1000; stall_o = 1 for 2 cycles; 2 bubbles; then valid store entry.
- LB at 0x2001, rdata = 0x0000_8000, gnt same cycle, rvalid 1 cycle later -> rd_data = 0xFFFF_FF80, RegWrite = 1; LBU same case -> rd_data = 0x0000_0080.
- LH at 0x2002 with rdata = 0x7FFF_0000 -> rd_data = 0x0000_7FFF. LW at 0x2002 -> no req, misalign_o pulse, RegWrite = 0.
- Load outstanding in WAIT_RSP, rst_n pulsed low -> outputs 0 immediately; rvalid after reset ignored; bus_out stays valid = 0.
- Back-to-back SW then LW, each with gnt same cycle and rvalid next cycle -> store completes with no stall; load stalls exactly 1 cycle; in-order MEM/WB entries.
